ctrl_pipe_hazard: RTL and testbench
===================================

Name: ctrl_pipe_hazard

Overview:
- Consumes the control bundle produced by the ID-stage instruction decoder and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles.
- Applies branch-taken flushes.
- Drives PC and IF/ID write enables.
- Sits between the decoder and the EX/MEM/WB datapath stages of the 5-stage RV32 core.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID-stage instruction is real (not a bubble).
- id_alu_op  in  2  decoder ALUOp (00 add, 01 branch compare, 10 R-type).
- id_alu_src  in  1  decoder ALUSrc.
- id_branch  in  1  decoder branch.
- id_mem_read  in  1  decoder mem_read.
- id_mem_write  in  1  decoder mem_write.
- id_reg_write  in  1  decoder reg_write.
- id_mem_to_reg  in  1  decoder mem_to_reg (may be X when id_reg_write=0).
- id_rs1  in  REG_W  ID source register 1.
- id_rs2  in  REG_W  ID source register 2.
- id_rs2_used  in  1  rs2 is a real operand (R-type, SW, BEQ).
- id_rd  in  REG_W  ID destination register.
- branch_taken  in  1  EX-stage compare result.
- ex_valid, ex_alu_op[2], ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_rd[REG_W]  out  ID/EX register contents.
- mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_rd[REG_W]  out  EX/MEM register contents.
- wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd[REG_W]  out  MEM/WB register contents.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID update enable.
- ifid_flush  out  1  IF/ID must load a bubble.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage registers, valids and counters go to 0.
  - pc_write=1, ifid_write=1, ifid_flush=0 (combinational from the zeroed state).
- Bubble definition: valid=0 and every control bit 0 (alu_op=00, rd=0).
- Sanitizing at ID/EX capture:
  - mem_to_reg is forced 0 when id_reg_write=0.
  - When id_valid=0, all captured controls are 0.
- take = ex_valid & ex_branch & branch_taken (combinational).
- hazard is combinational and true when all of the following hold:
  - ex_valid, ex_mem_read and id_valid are 1;
  - ex_rd != 0;
  - ex_rd == id_rs1, or (id_rs2_used and ex_rd == id_rs2).
- Per rising edge:
  - EX/MEM <= ID/EX, always. On take, the branch instruction itself still advances.
  - MEM/WB <= EX/MEM, always. Stages never stall downstream of ID.
  - ID/EX <= bubble if take or hazard; otherwise the sanitized ID bundle.
- Outputs:
  - pc_write = ~hazard | take.
  - ifid_write = ~hazard | take.
  - ifid_flush = take.
- Priority: take overrides hazard. The ID instruction is on the wrong path, so no stall is applied and stall_cnt does not increment.
- Latency: ID-to-EX 1 cycle, EX-to-MEM 1 cycle, MEM-to-WB 1 cycle. WB controls appear 3 edges after ID capture.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_mem_read=0, so hazard clears.
- Back-to-back loads with chained dependencies each stall 1 cycle.
- Counters:
  - stall_cnt increments on each edge where hazard & ~take.
  - flush_cnt increments on each edge where take.
  - Both saturate at all-ones (no wrap).
- rd=0 never causes a hazard. Writes to x0 still propagate (regfile ignores them).
- Reset asserted mid-stall or mid-flush: state clears immediately; the next instruction after release proceeds with no stall.
- No X may reach any output once inputs are known, including a decoder X on mem_to_reg.

Test Plan:
- Reset, then LW x5 (id_mem_read=1, rd=5) followed by ADD rs1=5 → one cycle with pc_write=0, ifid_write=0.
  - Next edge: ex_valid=0, ex_reg_write=0. Following edge: ADD in EX, ex_alu_op=10. stall_cnt=1.
- LW rd=5 then ADDI with rs1=1, rs2 field=5, id_rs2_used=0 → no stall, pc_write stays 1, stall_cnt=0.
- LW rd=0 then ADD rs1=0 → no stall.
- BEQ in EX with branch_taken=1 while ID holds a dependent instruction after LW → ifid_flush=1, pc_write=1.
  - Next edge: ex_valid=0. flush_cnt=1, stall_cnt unchanged.
- SW with id_mem_to_reg=X and id_reg_write=0 → ex_mem_to_reg=0, then mem_mem_write=1 one edge later, wb_reg_write=0 a further edge later.
- Drive 2^CNT_W+3 hazards with CNT_W=2 → stall_cnt holds 3.
- Assert rst_n=0 asynchronously mid-stall → all outputs reset before the next clock edge.

Source files
------------

// File: rtl/ctrl_pipe_hazard_if.sv
// Control bundle between the ID-stage decoder, the control pipeline and the EX/MEM/WB datapath.
// The slave side is the control pipeline; the master side is the decoder/EX compare plus datapath consumers.
interface ctrl_pipe_hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [1:0]       id_alu_op;
  logic             id_alu_src;
  logic             id_branch;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_reg_write;
  logic             id_mem_to_reg;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             branch_taken;

  logic             ex_valid;
  logic [1:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic [REG_W-1:0] ex_rd;

  logic             mem_valid;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;
  logic [REG_W-1:0] mem_rd;

  logic             wb_valid;
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [REG_W-1:0] wb_rd;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_rs1, id_rs2, id_rs2_used, id_rd, branch_taken,
    output ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, ex_rd,
           mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_rd,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd,
           pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_rs1, id_rs2, id_rs2_used, id_rd, branch_taken,
    input  ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_mem_to_reg, ex_rd,
           mem_valid, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_rd,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd,
           pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubble insertion,
// taken-branch flush and saturating stall/flush event counters.
module ctrl_pipe_hazard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ctrl_pipe_hazard_if.slave   bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             w_take;
  logic             w_hazard;
  logic             w_capture;

  logic             r_ex_valid;
  logic [1:0]       r_ex_alu_op;
  logic             r_ex_alu_src;
  logic             r_ex_branch;
  logic             r_ex_mem_read;
  logic             r_ex_mem_write;
  logic             r_ex_reg_write;
  logic             r_ex_mem_to_reg;
  logic [REG_W-1:0] r_ex_rd;

  logic             r_mem_valid;
  logic             r_mem_mem_read;
  logic             r_mem_mem_write;
  logic             r_mem_reg_write;
  logic             r_mem_mem_to_reg;
  logic [REG_W-1:0] r_mem_rd;

  logic             r_wb_valid;
  logic             r_wb_reg_write;
  logic             r_wb_mem_to_reg;
  logic [REG_W-1:0] r_wb_rd;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_take    = r_ex_valid & r_ex_branch & bus.branch_taken;
  assign w_hazard  = r_ex_valid & r_ex_mem_read & bus.id_valid & (r_ex_rd != '0) &
                     ((r_ex_rd == bus.id_rs1) | (bus.id_rs2_used & (r_ex_rd == bus.id_rs2)));
  // A wrong-path or stalled ID instruction enters EX as a bubble.
  assign w_capture = bus.id_valid & ~w_take & ~w_hazard;

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_op     <= 2'b00;
      r_ex_alu_src    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_rd         <= '0;
    end else begin
      r_ex_valid      <= w_capture;
      r_ex_alu_op     <= {2{w_capture}} & bus.id_alu_op;
      r_ex_alu_src    <= w_capture & bus.id_alu_src;
      r_ex_branch     <= w_capture & bus.id_branch;
      r_ex_mem_read   <= w_capture & bus.id_mem_read;
      r_ex_mem_write  <= w_capture & bus.id_mem_write;
      r_ex_reg_write  <= w_capture & bus.id_reg_write;
      // AND with reg_write first so a decoder X on mem_to_reg never propagates.
      r_ex_mem_to_reg <= w_capture & bus.id_reg_write & bus.id_mem_to_reg;
      r_ex_rd         <= {REG_W{w_capture}} & bus.id_rd;
    end
  end

  // EX/MEM and MEM/WB boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid      <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_rd         <= '0;
      r_wb_valid       <= 1'b0;
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_rd          <= '0;
    end else begin
      r_mem_valid      <= r_ex_valid;
      r_mem_mem_read   <= r_ex_mem_read;
      r_mem_mem_write  <= r_ex_mem_write;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_mem_to_reg;
      r_mem_rd         <= r_ex_rd;
      r_wb_valid       <= r_mem_valid;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_rd          <= r_mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_hazard & ~w_take) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_take)             r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign bus.ex_valid       = r_ex_valid;
  assign bus.ex_alu_op      = r_ex_alu_op;
  assign bus.ex_alu_src     = r_ex_alu_src;
  assign bus.ex_branch      = r_ex_branch;
  assign bus.ex_mem_read    = r_ex_mem_read;
  assign bus.ex_mem_write   = r_ex_mem_write;
  assign bus.ex_reg_write   = r_ex_reg_write;
  assign bus.ex_mem_to_reg  = r_ex_mem_to_reg;
  assign bus.ex_rd          = r_ex_rd;
  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_mem_read   = r_mem_mem_read;
  assign bus.mem_mem_write  = r_mem_mem_write;
  assign bus.mem_reg_write  = r_mem_reg_write;
  assign bus.mem_mem_to_reg = r_mem_mem_to_reg;
  assign bus.mem_rd         = r_mem_rd;
  assign bus.wb_valid       = r_wb_valid;
  assign bus.wb_reg_write   = r_wb_reg_write;
  assign bus.wb_mem_to_reg  = r_wb_mem_to_reg;
  assign bus.wb_rd          = r_wb_rd;
  assign bus.pc_write       = ~w_hazard | w_take;
  assign bus.ifid_write     = ~w_hazard | w_take;
  assign bus.ifid_flush     = w_take;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: a stage-list model checked every cycle plus
// literal expectations for the key hazard, flush, sanitizing and reset scenarios.
module tb_ctrl_pipe_hazard;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
  ctrl_pipe_hazard_if #(.REG_W(REG_W), .CNT_W(2))     bus2 ();

  ctrl_pipe_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  ctrl_pipe_hazard #(.REG_W(REG_W), .CNT_W(2))     dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.id_valid      = bus.id_valid;
  assign bus2.id_alu_op     = bus.id_alu_op;
  assign bus2.id_alu_src    = bus.id_alu_src;
  assign bus2.id_branch     = bus.id_branch;
  assign bus2.id_mem_read   = bus.id_mem_read;
  assign bus2.id_mem_write  = bus.id_mem_write;
  assign bus2.id_reg_write  = bus.id_reg_write;
  assign bus2.id_mem_to_reg = bus.id_mem_to_reg;
  assign bus2.id_rs1        = bus.id_rs1;
  assign bus2.id_rs2        = bus.id_rs2;
  assign bus2.id_rs2_used   = bus.id_rs2_used;
  assign bus2.id_rd         = bus.id_rd;
  assign bus2.branch_taken  = bus.branch_taken;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: list of instructions occupying EX (1), MEM (2), WB (3), plus raw event counts.
  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } stage_t;

  stage_t m_st [1:3];
  int     m_stall;
  int     m_flush;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic m_take();
    return m_st[1].valid && m_st[1].branch && bus.branch_taken;
  endfunction

  function automatic logic m_hazard();
    if (!(m_st[1].valid && m_st[1].mem_read && bus.id_valid)) return 1'b0;
    if (m_st[1].rd == 5'd0) return 1'b0;
    return (m_st[1].rd == bus.id_rs1) || (bus.id_rs2_used && m_st[1].rd == bus.id_rs2);
  endfunction

  function automatic stage_t m_enter();
    stage_t s;
    s = '0;
    if (bus.id_valid && !m_take() && !m_hazard()) begin
      s.valid      = 1'b1;
      s.alu_op     = bus.id_alu_op;
      s.alu_src    = bus.id_alu_src;
      s.branch     = bus.id_branch;
      s.mem_read   = bus.id_mem_read;
      s.mem_write  = bus.id_mem_write;
      s.reg_write  = bus.id_reg_write;
      s.mem_to_reg = bus.id_reg_write ? (bus.id_mem_to_reg === 1'b1) : 1'b0;
      s.rd         = bus.id_rd;
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st[1] <= '0;
      m_st[2] <= '0;
      m_st[3] <= '0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (m_hazard() && !m_take()) m_stall <= m_stall + 1;
      if (m_take())                m_flush <= m_flush + 1;
      m_st[1] <= m_enter();
      m_st[2] <= m_st[1];
      m_st[3] <= m_st[2];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ex_valid",       bus.ex_valid,       m_st[1].valid);
      chk("ex_alu_op",      bus.ex_alu_op,      m_st[1].alu_op);
      chk("ex_alu_src",     bus.ex_alu_src,     m_st[1].alu_src);
      chk("ex_branch",      bus.ex_branch,      m_st[1].branch);
      chk("ex_mem_read",    bus.ex_mem_read,    m_st[1].mem_read);
      chk("ex_mem_write",   bus.ex_mem_write,   m_st[1].mem_write);
      chk("ex_reg_write",   bus.ex_reg_write,   m_st[1].reg_write);
      chk("ex_mem_to_reg",  bus.ex_mem_to_reg,  m_st[1].mem_to_reg);
      chk("ex_rd",          bus.ex_rd,          m_st[1].rd);
      chk("mem_valid",      bus.mem_valid,      m_st[2].valid);
      chk("mem_mem_read",   bus.mem_mem_read,   m_st[2].mem_read);
      chk("mem_mem_write",  bus.mem_mem_write,  m_st[2].mem_write);
      chk("mem_reg_write",  bus.mem_reg_write,  m_st[2].reg_write);
      chk("mem_mem_to_reg", bus.mem_mem_to_reg, m_st[2].mem_to_reg);
      chk("mem_rd",         bus.mem_rd,         m_st[2].rd);
      chk("wb_valid",       bus.wb_valid,       m_st[3].valid);
      chk("wb_reg_write",   bus.wb_reg_write,   m_st[3].reg_write);
      chk("wb_mem_to_reg",  bus.wb_mem_to_reg,  m_st[3].mem_to_reg);
      chk("wb_rd",          bus.wb_rd,          m_st[3].rd);
      chk("pc_write",       bus.pc_write,       !m_hazard() || m_take());
      chk("ifid_write",     bus.ifid_write,     !m_hazard() || m_take());
      chk("ifid_flush",     bus.ifid_flush,     m_take());
      chk("stall_cnt",      bus.stall_cnt,      sat(m_stall, 65535));
      chk("flush_cnt",      bus.flush_cnt,      sat(m_flush, 65535));
      chk("stall_cnt_w2",   bus2.stall_cnt,     sat(m_stall, 3));
      chk("flush_cnt_w2",   bus2.flush_cnt,     sat(m_flush, 3));
    end
  end

  task automatic set_id(input logic v, input logic [1:0] op, input logic as, input logic br,
                        input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                        input logic [4:0] rd);
    bus.id_valid      = v;
    bus.id_alu_op     = op;
    bus.id_alu_src    = as;
    bus.id_branch     = br;
    bus.id_mem_read   = mr;
    bus.id_mem_write  = mw;
    bus.id_reg_write  = rw;
    bus.id_mem_to_reg = m2r;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_rs2_used   = u;
    bus.id_rd         = rd;
  endtask

  task automatic bubble();
    set_id(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic lw(input logic [4:0] rs1, input logic [4:0] rd);
    set_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rs1, 5'd0, 1'b0, rd);
  endtask

  task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    set_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rs1, rs2, 1'b1, rd);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic load_use();
    lw(5'd1, 5'd5);
    nxt();
    add(5'd5, 5'd2, 5'd7);
    nxt();
    nxt();
    bubble();
  endtask

  initial begin
    bus.branch_taken = 1'b0;
    bubble();
    #12;
    chk("rst ex_valid",   bus.ex_valid,   1'b0);
    chk("rst wb_valid",   bus.wb_valid,   1'b0);
    chk("rst stall_cnt",  bus.stall_cnt,  16'd0);
    chk("rst pc_write",   bus.pc_write,   1'b1);
    chk("rst ifid_write", bus.ifid_write, 1'b1);
    chk("rst ifid_flush", bus.ifid_flush, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW x5 then dependent ADD: one stall cycle
    nxt(); lw(5'd1, 5'd5);
    nxt(); add(5'd5, 5'd6, 5'd7);
    mid();
    chk("lu pc_write",   bus.pc_write,   1'b0);
    chk("lu ifid_write", bus.ifid_write, 1'b0);
    nxt();
    chk("lu bubble ex_valid",     bus.ex_valid,     1'b0);
    chk("lu bubble ex_reg_write", bus.ex_reg_write, 1'b0);
    mid();
    chk("lu cleared pc_write", bus.pc_write, 1'b1);
    nxt();
    chk("lu add ex_alu_op", bus.ex_alu_op, 2'b10);
    chk("lu add ex_rd",     bus.ex_rd,     5'd7);
    chk("lu stall_cnt",     bus.stall_cnt, 16'd1);
    bubble();

    // rs2 field matches but is not a real operand
    nxt(); lw(5'd1, 5'd5);
    nxt(); set_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 1'b0, 5'd8);
    mid();
    chk("rs2unused pc_write", bus.pc_write, 1'b1);
    nxt();
    chk("rs2unused ex_rd",     bus.ex_rd,     5'd8);
    chk("rs2unused stall_cnt", bus.stall_cnt, 16'd1);

    // load to x0 never stalls
    lw(5'd1, 5'd0);
    nxt(); add(5'd0, 5'd0, 5'd9);
    mid();
    chk("x0 pc_write", bus.pc_write, 1'b1);
    nxt();
    chk("x0 ex_valid", bus.ex_valid, 1'b1);

    // taken branch flushes the dependent instruction behind it
    lw(5'd1, 5'd5);
    nxt(); set_id(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 5'd3, 1'b1, 5'd0);
    nxt(); add(5'd5, 5'd2, 5'd7); bus.branch_taken = 1'b1;
    mid();
    chk("br ifid_flush", bus.ifid_flush, 1'b1);
    chk("br pc_write",   bus.pc_write,   1'b1);
    nxt();
    bus.branch_taken = 1'b0;
    chk("br ex_valid",    bus.ex_valid,  1'b0);
    chk("br mem_valid",   bus.mem_valid, 1'b1);
    chk("br flush_cnt",   bus.flush_cnt, 16'd1);
    chk("br stall_cnt",   bus.stall_cnt, 16'd1);

    // take overrides a simultaneous hazard
    set_id(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5);
    nxt(); add(5'd5, 5'd2, 5'd7); bus.branch_taken = 1'b1;
    mid();
    chk("prio pc_write",   bus.pc_write,   1'b1);
    chk("prio ifid_flush", bus.ifid_flush, 1'b1);
    nxt();
    bus.branch_taken = 1'b0;
    chk("prio stall_cnt", bus.stall_cnt, 16'd1);
    chk("prio flush_cnt", bus.flush_cnt, 16'd2);
    chk("prio ex_valid",  bus.ex_valid,  1'b0);

    // SW with unknown mem_to_reg, then with mem_to_reg=1, then invalid ID bundle
    set_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'bx, 5'd2, 5'd5, 1'b1, 5'd0);
    nxt();
    chk("sw ex_mem_to_reg", bus.ex_mem_to_reg, 1'b0);
    chk("sw ex_mem_write",  bus.ex_mem_write,  1'b1);
    set_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 5'd5, 1'b1, 5'd0);
    nxt();
    chk("sw2 ex_mem_to_reg", bus.ex_mem_to_reg, 1'b0);
    chk("sw mem_mem_write",  bus.mem_mem_write, 1'b1);
    set_id(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd9);
    nxt();
    chk("sw wb_reg_write",   bus.wb_reg_write,  1'b0);
    chk("sw wb_valid",       bus.wb_valid,      1'b1);
    chk("inv ex_reg_write",  bus.ex_reg_write,  1'b0);
    chk("inv ex_rd",         bus.ex_rd,         5'd0);
    bubble();

    // chained loads: each dependency stalls once
    nxt(); lw(5'd1, 5'd5);
    nxt(); lw(5'd5, 5'd6);
    mid(); chk("chain1 pc_write", bus.pc_write, 1'b0);
    nxt(); mid(); chk("chain1 release", bus.pc_write, 1'b1);
    nxt(); add(5'd6, 5'd0, 5'd7);
    mid(); chk("chain2 pc_write", bus.pc_write, 1'b0);
    nxt(); nxt(); bubble();
    chk("chain stall_cnt", bus.stall_cnt, 16'd3);

    for (int i = 0; i < 4; i++) load_use();
    nxt();
    chk("sat main stall_cnt", bus.stall_cnt,  16'd7);
    chk("sat w2 stall_cnt",   bus2.stall_cnt, 2'd3);
    chk("sat w2 flush_cnt",   bus2.flush_cnt, 2'd2);

    // asynchronous reset in the middle of a stall
    lw(5'd1, 5'd5);
    nxt(); add(5'd5, 5'd2, 5'd7);
    mid();
    chk("mr stalled", bus.pc_write, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr ex_valid",   bus.ex_valid,   1'b0);
    chk("mr mem_valid",  bus.mem_valid,  1'b0);
    chk("mr stall_cnt",  bus.stall_cnt,  16'd0);
    chk("mr flush_cnt",  bus.flush_cnt,  16'd0);
    chk("mr pc_write",   bus.pc_write,   1'b1);
    chk("mr ifid_flush", bus.ifid_flush, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mid();
    chk("post pc_write", bus.pc_write, 1'b1);
    nxt();
    chk("post ex_valid",  bus.ex_valid,  1'b1);
    chk("post stall_cnt", bus.stall_cnt, 16'd0);
    bubble();
    repeat (4) nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
